// File: rtl/sll_iter.sv
// Multi-cycle left shifter: shifts a captured operand by up to STEP bits per cycle.
// Optional macro SLL_ROTATE_EN adds a rotate input selecting left rotate instead of shift.
module sll_iter #(
   parameter int unsigned N    = 32,
   parameter int unsigned STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in,
   input  logic [$clog2(N)-1:0] shamt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out
`ifdef SLL_ROTATE_EN
   ,
   input  logic                 rotate
`endif
);

   localparam int unsigned W = $clog2(N);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [N-1:0] data_q, data_d;
   logic [W-1:0] rem_q, rem_d;
   logic [W-1:0] k;
   logic [N-1:0] stepped;
   logic         accept;

`ifdef SLL_ROTATE_EN
   logic rot_q, rot_d;
`endif

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign out_valid = (state_q == S_DONE);
   assign out       = data_q;
   assign accept    = in_valid & in_ready;

   // STEP may exceed any representable rem, so compare at 32 bits before narrowing.
   always_comb begin
      if (32'(rem_q) < STEP) k = rem_q;
      else                   k = W'(STEP);
   end

   always_comb begin
      stepped = data_q << k;
`ifdef SLL_ROTATE_EN
      if (rot_q) stepped = (data_q << k) | (data_q >> (N - 32'(k)));
`endif
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
`ifdef SLL_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         S_IDLE: ;
         S_SHIFT: begin
            data_d  = stepped;
            rem_d   = rem_q - k;
            state_d = (rem_q == k) ? S_DONE : S_SHIFT;
         end
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A new request in DONE retires the current result on the same edge.
      if (accept) begin
         data_d  = in;
         rem_d   = shamt;
         state_d = (shamt != '0) ? S_SHIFT : S_DONE;
`ifdef SLL_ROTATE_EN
         rot_d   = rotate;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
`ifdef SLL_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
`ifdef SLL_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

endmodule

// File: tb/tb_sll_iter.sv
// Bench for sll_iter: two instances (STEP=1 and STEP=4, N=32) checked every cycle
// against a transaction-level model, plus directed literal cases.
module tb_sll_iter;

   logic        clk;
   logic        rst_n;
   logic        iv   [2];
   logic        ir   [2];
   logic [31:0] din  [2];
   logic [4:0]  sh   [2];
   logic        rot  [2];
   logic        ov   [2];
   logic        ordy [2];
   logic [31:0] dout [2];

   int checks = 0;
   int errors = 0;

`ifdef SLL_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sll_iter #(
         .N    (32),
         .STEP ((g == 0) ? 1 : 4)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in        (din[g]),
         .shamt     (sh[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out       (dout[g])
`ifdef SLL_ROTATE_EN
         ,
         .rotate    (rot[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int step_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] a, input int s, input bit r);
      logic [63:0] t;
      t = {a, a} << s;
      if (r) return t[63:32];
      return a << s;
   endfunction

   // Transaction model: one outstanding op per instance with a predicted ready cycle.
   int          cyc = 0;
   bit          busy     [2];
   int          ready_at [2];
   logic [31:0] expv     [2];

   function automatic bit exp_valid(input int i);
      return busy[i] && (cyc >= ready_at[i]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) busy[i] = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit ev, eir;
            ev  = exp_valid(i);
            eir = !busy[i] || (ev && ordy[i]);
            if (ev && ordy[i]) busy[i] = 1'b0;
            if (iv[i] && eir) begin
               busy[i]     = 1'b1;
               expv[i]     = ref_result(din[i], int'(sh[i]), ROT_EN & rot[i]);
               ready_at[i] = cyc + 1 + (int'(sh[i]) + step_of(i) - 1) / step_of(i);
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit ev;
         ev = exp_valid(i);
         chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ev));
         chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(!busy[i] || (ev && ordy[i])));
         if (ev) chk($sformatf("out[%0d]", i), dout[i], expv[i]);
      end
   end

   // Directed op; starts and ends just after a rising edge.
   task automatic do_op(input int i, input logic [31:0] a, input logic [4:0] s, input logic r,
                        input int hold, input bit rel, input logic [31:0] expo,
                        input int explat, input string name);
      int wcnt;
      int lat;
      iv[i] = 1'b1; din[i] = a; sh[i] = s; rot[i] = r; ordy[i] = 1'b0;
      wcnt = 0;
      do begin @(negedge clk); wcnt++; end while (!ir[i] && wcnt < 20);
      chk({name, "_accept"}, 32'(ir[i]), 32'd1);
      @(posedge clk); #1;
      iv[i] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!ov[i]) chk({name, "_busy_in_ready"}, 32'(ir[i]), 32'd0);
      end while (!ov[i] && lat < 80);
      chk({name, "_latency"}, lat, explat);
      chk({name, "_out"}, dout[i], expo);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({name, "_hold_valid"}, 32'(ov[i]), 32'd1);
         chk({name, "_hold_out"}, dout[i], expo);
         chk({name, "_hold_in_ready"}, 32'(ir[i]), 32'd0);
      end
      @(posedge clk); #1;
      if (rel) begin
         ordy[i] = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic drive_rand(input int i, input int n);
      bit acc;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         acc = iv[i] & ir[i];
         @(posedge clk); #1;
         if (acc || !iv[i]) begin
            iv[i]  = ($urandom % 3) != 0;
            din[i] = $urandom;
            sh[i]  = 5'($urandom);
            rot[i] = 1'($urandom);
         end
         ordy[i] = ($urandom % 4) != 0;
      end
      @(posedge clk); #1;
      iv[i] = 1'b0; ordy[i] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; din[i] = '0; sh[i] = '0; rot[i] = 1'b0; ordy[i] = 1'b1;
      end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_out", dout[i], 32'h0);
         chk("reset_out_valid", 32'(ov[i]), 32'd0);
         chk("reset_in_ready", 32'(ir[i]), 32'd1);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(0, 32'h0000_0001, 5'd31, 1'b0, 0, 1'b1, 32'h8000_0000, 32, "step1_sh31");
      do_op(1, 32'hF000_000F, 5'd6, 1'b0, 0, 1'b1, 32'h0000_03C0, 3, "step4_sh6");
      do_op(1, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 1'b1, 32'hDEAD_BEEF, 1, "sh0");

      // Backpressure, then retire and accept on the same edge.
      do_op(1, 32'h0000_0F0F, 5'd8, 1'b0, 5, 1'b0, 32'h000F_0F00, 3, "bp");
      iv[1] = 1'b1; din[1] = 32'h1; sh[1] = 5'd1; rot[1] = 1'b0; ordy[1] = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 32'(ir[1]), 32'd1);
      chk("b2b_old_valid", 32'(ov[1]), 32'd1);
      @(posedge clk); #1;
      iv[1] = 1'b0;
      @(negedge clk);
      chk("b2b_shift_valid", 32'(ov[1]), 32'd0);
      @(negedge clk);
      chk("b2b_new_valid", 32'(ov[1]), 32'd1);
      chk("b2b_new_out", dout[1], 32'h2);
      @(posedge clk); #1;

      // Asynchronous reset mid-operation.
      iv[0] = 1'b1; din[0] = 32'h1234_5678; sh[0] = 5'd20; ordy[0] = 1'b1;
      @(negedge clk);
      chk("rst_op_accept", 32'(ir[0]), 32'd1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out", dout[0], 32'h0);
      chk("midrst_out_valid", 32'(ov[0]), 32'd0);
      chk("midrst_in_ready", 32'(ir[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(0, 32'h0000_00FF, 5'd4, 1'b0, 0, 1'b1, 32'h0000_0FF0, 5, "post_rst");

`ifdef SLL_ROTATE_EN
      do_op(0, 32'h8000_0001, 5'd1, 1'b1, 0, 1'b1, 32'h0000_0003, 2, "rot1");
      do_op(1, 32'h1234_5678, 5'd8, 1'b1, 0, 1'b1, 32'h3456_7812, 3, "rot8");
`endif
      do_op(0, 32'h8000_0001, 5'd1, 1'b0, 0, 1'b1, 32'h0000_0002, 2, "lsl1");

      fork
         drive_rand(0, 700);
         drive_rand(1, 700);
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
